// File: rtl/cavlc_coeff_token_enc.sv
// CAVLC coeff_token encoder for every nC class (VLC0/1/2, FLC, chroma DC).
// Two-stage valid/ready pipeline: S1 registers the table select and the
// operands, S2 registers the looked-up codeword. A saturating counter sums
// the lengths of legal codewords accepted downstream.
module cavlc_coeff_token_enc #(
  parameter int CNT_W   = 12,
  parameter bit ERR_CHK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       nc_i,
  input  logic [4:0]       total_coeff_i,
  input  logic [1:0]       trailing_ones_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      code_o,
  output logic [4:0]       len_o,
  output logic             err_o,
  input  logic             bits_clr_i,
  output logic [CNT_W-1:0] bits_total_o
);

  typedef enum logic [2:0] {SEL_VLC0, SEL_VLC1, SEL_VLC2, SEL_FLC, SEL_CDC} sel_e;

  // Code tables indexed by TotalCoeff*4 + TrailingOnes; codes are right-aligned.
  localparam int VLC_LEN [3][68] = '{
    '{ 1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,  11,10, 9, 7,
      13,11,10, 8,  13,13,11, 9,  13,13,13,10,  14,14,13,11,  14,14,14,13,  15,15,14,14,
      15,15,15,14,  16,15,15,15,  16,16,16,15,  16,16,16,16,  16,16,16,16},
    '{ 2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,   8, 7, 7, 5,
       9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,  12,11,11, 9,  12,12,12,11,  12,12,12,11,
      13,13,13,12,  13,13,13,13,  13,14,13,13,  14,14,14,13,  14,14,14,14},
    '{ 4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,   7, 5, 5, 4,
       7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,   8, 8, 7, 6,   9, 8, 8, 7,   9, 9, 8, 8,
       9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,  10,10,10,10,  10,10,10,10}
  };
  localparam int VLC_BITS [3][68] = '{
    '{ 1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,   7, 6, 5, 4,
      15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,  15,14, 9, 4,  11,10,13,12,  15,14, 9,12,
      11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,   7,10, 9,12,   4, 6, 5, 8},
    '{ 3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,   4, 6, 5, 6,
       7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,  15,10, 9, 4,  11,14,13,12,   8,10, 9, 8,
      15,14,13,12,  11,10, 9,12,   7,11, 6, 8,   9, 8,10, 1,   7, 6, 5, 4},
    '{15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,  11, 8, 9,10,
       9,14,13, 9,   8,10, 9, 8,  15,14,13,13,  11,14,10,12,  15,10,13,12,  11,14, 9,12,
       8,10,13, 8,  13, 7, 9,12,   9,12,11,10,   5, 8, 7, 6,   1, 4, 3, 2}
  };
  localparam int CDC_LEN  [20] = '{2,0,0,0, 6,1,0,0, 6,6,3,0, 6,7,7,6, 6,8,8,7};
  localparam int CDC_BITS [20] = '{1,0,0,0, 7,1,0,0, 4,6,1,0, 3,3,2,5, 2,3,2,0};

  localparam int SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;

  logic signed [5:0] nc_s;
  sel_e              in_sel, s1_sel;
  logic              in_err, s1_err, s1_valid, s2_adv;
  logic [4:0]        s1_tc;
  logic [1:0]        s1_to;
  logic [6:0]        vlc_idx;
  logic [4:0]        cdc_idx;
  logic [15:0]       lk_code;
  logic [4:0]        lk_len;
  logic [4:0]        hs_len;
  logic [SUM_W-1:0]  bits_sum;
  logic [CNT_W-1:0]  bits_next;

  assign nc_s     = $signed(nc_i);
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign vlc_idx  = {s1_tc, s1_to};
  assign cdc_idx  = {s1_tc[2:0], s1_to};

  // Classify nC into a table and flag operand combinations with no codeword.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    in_sel = SEL_CDC;
    if (nc_s >= 6'sd8)      in_sel = SEL_FLC;
    else if (nc_s >= 6'sd4) in_sel = SEL_VLC2;
    else if (nc_s >= 6'sd2) in_sel = SEL_VLC1;
    else if (nc_s >= 6'sd0) in_sel = SEL_VLC0;
    in_err = 1'b0;
    if (ERR_CHK) begin
      in_err = ({3'b000, trailing_ones_i} > total_coeff_i) || (total_coeff_i > 5'd16) ||
               (nc_s < -6'sd1) || ((nc_s == -6'sd1) && (total_coeff_i > 5'd4));
    end
  end

  // S1: capture a request whenever the stage is free or draining into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset along with the valid bit so the pipe holds known values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= SEL_VLC0;
      s1_tc    <= '0;
      s1_to    <= '0;
      s1_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sel <= in_sel;
        s1_tc  <= total_coeff_i;
        s1_to  <= trailing_ones_i;
        s1_err <= in_err;
      end
    end
  end

  // Table lookup on the S1 operands; illegal entries produce an empty codeword.
  always_comb begin
    lk_code = '0;
    lk_len  = '0;
    unique case (s1_sel)
      SEL_VLC0: begin lk_len = 5'(VLC_LEN[0][vlc_idx]); lk_code = 16'(VLC_BITS[0][vlc_idx]); end
      SEL_VLC1: begin lk_len = 5'(VLC_LEN[1][vlc_idx]); lk_code = 16'(VLC_BITS[1][vlc_idx]); end
      SEL_VLC2: begin lk_len = 5'(VLC_LEN[2][vlc_idx]); lk_code = 16'(VLC_BITS[2][vlc_idx]); end
      SEL_FLC: begin
        lk_len  = 5'd6;
        lk_code = (s1_tc == 5'd0) ? 16'd3 : {10'd0, 4'(s1_tc - 5'd1), s1_to};
      end
      SEL_CDC:  begin lk_len = 5'(CDC_LEN[cdc_idx]); lk_code = 16'(CDC_BITS[cdc_idx]); end
      default: ;
    endcase
    if (s1_err) begin
      lk_code = '0;
      lk_len  = '0;
    end
  end

  // S2: register the codeword; it holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code_o    <= '0;
      len_o     <= '0;
      err_o     <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        code_o <= lk_code;
        len_o  <= lk_len;
        err_o  <= s1_err;
      end
    end
  end

  // Next bit total: clear drops the old total but keeps a coincident handshake.
  always_comb begin
    hs_len    = (out_valid && out_ready && !err_o) ? len_o : 5'd0;
    bits_sum  = (bits_clr_i ? '0 : SUM_W'(bits_total_o)) + SUM_W'(hs_len);
    bits_next = (|bits_sum[SUM_W-1:CNT_W]) ? '1 : bits_sum[CNT_W-1:0];
  end

  // Saturating coeff_token bit accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bits_total_o <= '0;
    else        bits_total_o <= bits_next;
  end

endmodule

// File: tb/tb_cavlc_coeff_token_enc.sv
// Bench for cavlc_coeff_token_enc: directed requests push hand-computed
// codewords into a scoreboard; a negedge monitor compares every presented
// output and tracks the expected bit totals for a 12-bit and a 4-bit counter.
module tb_cavlc_coeff_token_enc;

  typedef struct {
    logic [15:0] code;
    logic [4:0]  len;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err_o, bits_clr_i;
  logic [5:0]  nc_i;
  logic [4:0]  total_coeff_i, len_o;
  logic [1:0]  trailing_ones_i;
  logic [15:0] code_o;
  logic [11:0] bits_total_o;
  logic        sat_in_ready, sat_out_valid, sat_err;
  logic [15:0] sat_code;
  logic [4:0]  sat_len;
  logic [3:0]  sat_total;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   exp_total = 0;
  int   exp_sat   = 0;
  bit   mon_en    = 1'b0;

  cavlc_coeff_token_enc #(.CNT_W(12), .ERR_CHK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .nc_i(nc_i), .total_coeff_i(total_coeff_i), .trailing_ones_i(trailing_ones_i),
    .out_valid(out_valid), .out_ready(out_ready), .code_o(code_o), .len_o(len_o),
    .err_o(err_o), .bits_clr_i(bits_clr_i), .bits_total_o(bits_total_o));

  cavlc_coeff_token_enc #(.CNT_W(4), .ERR_CHK(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .nc_i(nc_i), .total_coeff_i(total_coeff_i), .trailing_ones_i(trailing_ones_i),
    .out_valid(sat_out_valid), .out_ready(out_ready), .code_o(sat_code), .len_o(sat_len),
    .err_o(sat_err), .bits_clr_i(bits_clr_i), .bits_total_o(sat_total));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int sat_add(input int base, input int add, input int max);
    return (base + add > max) ? max : base + add;
  endfunction

  // Monitor: compare presented outputs with the scoreboard head, track totals.
  always @(negedge clk) begin : mon
    exp_t e;
    int   add;
    if (rst_n && mon_en) begin
      check("bits_total", 32'(bits_total_o), 32'(exp_total));
      check("bits_total_sat", 32'(sat_total), 32'(exp_sat));
      add = 0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got code=%0h len=%0d with empty scoreboard", code_o, len_o);
        end else begin
          e = sb[0];
          check("code", 32'(code_o), 32'(e.code));
          check("len", 32'(len_o), 32'(e.len));
          check("err", 32'(err_o), 32'(e.err));
          if (out_ready) begin
            void'(sb.pop_front());
            n_out++;
            if (!e.err) add = int'(e.len);
          end
        end
      end
      exp_total = bits_clr_i ? sat_add(0, add, 4095) : sat_add(exp_total, add, 4095);
      exp_sat   = bits_clr_i ? sat_add(0, add, 15)   : sat_add(exp_sat, add, 15);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one request (called just after a posedge); push its expectation on accept.
  task automatic send(input int nc, input int tc, input int to, input int code, input int len,
                      input bit err, output int waits);
    exp_t e;
    nc_i = 6'(nc);
    total_coeff_i = 5'(tc);
    trailing_ones_i = 2'(to);
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    if (in_ready) begin
      e.code = 16'(code);
      e.len  = 5'(len);
      e.err  = err;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int n;
    int out_before;
    rst_n = 1'b0;
    in_valid = 1'b0;
    nc_i = '0;
    total_coeff_i = '0;
    trailing_ones_i = '0;
    out_ready = 1'b1;
    bits_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(code_o), 32'd0);
    check("rst_len", 32'(len_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_bits_total", 32'(bits_total_o), 32'd0);
    sync();
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single request and two-cycle latency.
    sync();
    send(0, 0, 0, 1, 1, 1'b0, w);
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();
    check("t1_bits_total", 32'(bits_total_o), 32'd1);

    // Clear with no handshake.
    sync();
    bits_clr_i = 1'b1;
    sync();
    bits_clr_i = 1'b0;
    @(negedge clk);
    check("clr_alone_total", 32'(bits_total_o), 32'd0);

    // Back-to-back across VLC1, VLC2 and FLC.
    sync();
    send(2, 1, 1, 'b10, 2, 1'b0, w);     check("b2b_ready0", 32'(w), 32'd0);
    send(5, 0, 0, 'b1111, 4, 1'b0, w);   check("b2b_ready1", 32'(w), 32'd0);
    send(5, 1, 0, 'b001111, 6, 1'b0, w); check("b2b_ready2", 32'(w), 32'd0);
    send(9, 5, 2, 'b010010, 6, 1'b0, w); check("b2b_ready3", 32'(w), 32'd0);
    drain();
    check("b2b_bits_total", 32'(bits_total_o), 32'd18);
    check("b2b_bits_sat", 32'(sat_total), 32'd15);

    // Chroma DC.
    sync();
    send(-1, 1, 1, 'b1, 1, 1'b0, w);
    send(-1, 0, 0, 'b01, 2, 1'b0, w);
    send(-1, 3, 3, 'b000101, 6, 1'b0, w);
    send(-1, 4, 0, 'b000010, 6, 1'b0, w);
    drain();
    check("cdc_bits_total", 32'(bits_total_o), 32'd33);

    // Illegal inputs.
    sync();
    send(0, 1, 2, 0, 0, 1'b1, w);
    send(-1, 5, 0, 0, 0, 1'b1, w);
    send(-3, 0, 0, 0, 0, 1'b1, w);
    drain();
    check("err_bits_total", 32'(bits_total_o), 32'd33);

    // Backpressure: two entries fill the pipe, the third waits for release.
    out_before = n_out;
    sync();
    out_ready = 1'b0;
    send(2, 1, 1, 'b10, 2, 1'b0, w);  check("bp_a_ready", 32'(w), 32'd0);
    send(0, 2, 2, 'b001, 3, 1'b0, w); check("bp_b_ready", 32'(w), 32'd0);
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    sync();
    fork
      begin
        send(2, 0, 0, 'b11, 2, 1'b0, w);
        check("bp_c_stalled", 32'(w > 0), 32'd1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_out_count", 32'(n_out - out_before), 32'd3);
    check("bp_bits_total", 32'(bits_total_o), 32'd40);

    // Clear coincident with a len-6 handshake.
    sync();
    out_ready = 1'b0;
    send(8, 3, 1, 'b001001, 6, 1'b0, w);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_wait_valid", 32'(out_valid), 32'd1);
    sync();
    bits_clr_i = 1'b1;
    out_ready = 1'b1;
    sync();
    bits_clr_i = 1'b0;
    @(negedge clk);
    check("clr_hs_total", 32'(bits_total_o), 32'd6);
    check("clr_hs_sat", 32'(sat_total), 32'd6);

    // Longest codes of each table plus FLC TC=0; 4-bit total pins at 15.
    sync();
    send(0, 16, 3, 'b0000000000001000, 16, 1'b0, w);
    send(2, 16, 3, 'b00000000000100, 14, 1'b0, w);
    send(4, 16, 3, 'b0000000010, 10, 1'b0, w);
    send(8, 0, 0, 'b000011, 6, 1'b0, w);
    drain();
    check("final_bits_total", 32'(bits_total_o), 32'd52);
    check("final_bits_sat", 32'(sat_total), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_token_enc.md
Name: cavlc_coeff_token_enc

Overview:
- Complete CAVLC coeff_token encoder covering every nC class of H.264 Table 9-5:
  - VLC0: 0<=nC<2
  - VLC1: 2<=nC<4
  - VLC2: 4<=nC<8
  - FLC: nC>=8
  - chroma DC: nC==-1
- Two-stage valid/ready pipeline. Emits a right-aligned codeword and its length.
- Accumulates a per-block coeff_token bit count for rate estimation.
- Sits between the CAVLC coefficient scanner and the bitstream packer.

Parameters:
- CNT_W, 12, width of the bits_total_o accumulator (saturating).
- ERR_CHK, 1, 1 enables illegal-input detection; 0 treats all inputs as legal (illegal results undefined).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- in_valid  input  1  input request valid
- in_ready  output  1  encoder can accept input this cycle
- nc_i  input  6  signed nC (two's complement, -32..31)
- total_coeff_i  input  5  TotalCoeff, 0..16
- trailing_ones_i  input  2  TrailingOnes, 0..3
- out_valid  output  1  codeword valid
- out_ready  input  1  downstream accepts codeword
- code_o  output  16  codeword, right-aligned, MSB-first transmit order
- len_o  output  5  codeword length, 1..16; 0 on error
- err_o  output  1  illegal input for this result
- bits_clr_i  input  1  synchronous clear of bits_total_o
- bits_total_o  output  CNT_W  sum of len_o over handshaken outputs since last clear

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, out_valid=0, code_o=0, len_o=0, err_o=0, bits_total_o=0. in_ready=1 after release.
- Stage 1 (S1):
  - Registers table select from nC: sel=FLC if nC>=8, VLC2 if nC>=4, VLC1 if nC>=2, VLC0 if nC>=0, CDC if nC==-1, illegal otherwise.
  - Registers total_coeff_i, trailing_ones_i and the err flag.
- Stage 2 (S2): combinational table lookup on S1 registers; result registered into code_o/len_o/err_o/out_valid.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv.
  - Input accepted when in_valid && in_ready.
  - S1 moves into S2 when s1_valid && s2_adv.
- Latency: 2 cycles from accept to out_valid with no backpressure. Throughput 1 per cycle.
- Stall: code_o/len_o/err_o hold stable while out_valid && !out_ready. No data loss; 2 entries maximum in flight.
- Error conditions (ERR_CHK=1): trailing_ones > total_coeff, total_coeff > 16, nC < -1, or nC==-1 with total_coeff > 4.
  - Result: err_o=1, code_o=0, len_o=0. The entry still traverses the pipe and consumes a handshake.
- FLC (nC>=8): len=6.
  - TC=0 → code 6'b000011.
  - Otherwise code = ((TC-1)<<2) | TO.
- VLC0/1/2 and CDC: exact Table 9-5 codes, len 1..16.
- Bit count: on each out_valid && out_ready with err_o=0, bits_total_o += len_o, saturating at 2^CNT_W-1.
- bits_clr_i has priority:
  - bits_clr_i with a simultaneous handshake → bits_total_o = len_o of that handshake.
  - bits_clr_i alone → 0.
- Reset mid-operation: all in-flight entries are discarded immediately. No output is produced for them.

Test Plan:
- Reset, then one request nC=0, TC=0, TO=0 with out_ready=1 → out_valid two cycles after accept; code=1, len=1, err=0; bits_total=1.
- Four back-to-back requests, out_ready=1: (nC=2,TC=1,TO=1), (nC=5,TC=0,TO=0), (nC=5,TC=1,TO=0), (nC=9,TC=5,TO=2) → successive outputs code=2'b10/len 2, 4'b1111/len 4, 6'b001111/len 6, 6'b010010/len 6; in_ready stays 1; bits_total=18.
- Chroma DC, nC=-1: (TC=1,TO=1) → code 1/len 1; (TC=0) → code 01/len 2; (TC=3,TO=3) → code 000101/len 6; (TC=4,TO=0) → code 000010/len 6.
- Illegal inputs: (nC=0,TC=1,TO=2), (nC=-1,TC=5,TO=0), (nC=-3,TC=0,TO=0) → err_o=1, len=0, code=0 each; bits_total unchanged.
- Backpressure: hold out_ready=0 for 5 cycles while sending 3 requests → in_ready falls after the 2nd accept; the first output holds stable; on release all 3 outputs emerge in order with no loss or duplication.
- bits_clr_i asserted in the same cycle as a handshake of len 6 with prior total 40 → bits_total=6. Saturation check with CNT_W=4: the total stays at 15.
